// File: rtl/regfile_wb_arbiter_pkg.sv
// Register-file constants, arbiter port bundles and pointer helper,
// shared between the write-back arbiter and the register file.
package regfile_wb_arbiter_pkg;

  localparam int RF_SEL_W    = 4;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 1 << RF_SEL_W;
  localparam int WB_NUM_REQ  = 3;

  typedef struct packed {
    logic                             hold;
    logic [WB_NUM_REQ-1:0]            req_valid;
    logic [WB_NUM_REQ*RF_SEL_W-1:0]   req_sel;
    logic [WB_NUM_REQ*RF_DATA_W-1:0]  req_data;
  } PortIn_WbArbiter;

  typedef struct packed {
    logic [WB_NUM_REQ-1:0] req_ready;
    logic                  wr_en;
    logic [RF_SEL_W-1:0]   wr_sel;
    logic [RF_DATA_W-1:0]  wr_data;
    logic                  busy;
  } PortOut_WbArbiter;

  // (g+1) mod num_req without a divider
  function automatic int next_ptr(input int g, input int num_req);
    return (g >= num_req - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_pick.sv
// Combinational one-hot picker: first valid bit at or after start_idx,
// wrapping around; also returns the encoded winner index.
module regfile_wb_arbiter_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] start_idx,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(start_idx) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!grant_any && valid[cand_idx]) begin
        grant_any       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Build option REGFILE_WB_ARBITER_ROUND_ROBIN_EN: round-robin; otherwise fixed priority.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int SEL_W   = RF_SEL_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [SEL_W-1:0]          wr_sel,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] valid_gated;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   start_idx;
  logic               grant_any;
  logic [SEL_W-1:0]   sel_mux;
  logic [DATA_W-1:0]  data_mux;

  // Reset and hold both mask every request before arbitration
  assign valid_gated = (rst || hold) ? '0 : req_valid;

`ifdef REGFILE_WB_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) ptr_d = IDX_W'(next_ptr(int'(grant_idx), NUM_REQ));
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign start_idx = ptr_q;
`else
  assign start_idx = '0;
`endif

  regfile_wb_arbiter_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid     (valid_gated),
    .start_idx (start_idx),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  always_comb begin
    sel_mux  = '0;
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_mux  = req_sel[i*SEL_W +: SEL_W];
        data_mux = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // r0 writes are consumed but never enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      wr_en <= grant_any && (sel_mux != '0);
      if (grant_any) begin
        wr_sel  <= sel_mux;
        wr_data <= data_mux;
      end
      busy <= |(req_valid & ~grant);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter with a behavioural
// arbitration model and a bench-side register file fed from the DUT outputs.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int SW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            hold = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*SW-1:0] req_sel = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            wr_en;
  logic [SW-1:0]   wr_sel;
  logic [DW-1:0]   wr_data;
  logic            busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .SEL_W(SW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  logic [DW-1:0] tb_rf [16] = '{default: '0};
  always @(posedge clk) if (wr_en === 1'b1) tb_rf[wr_sel] <= wr_data;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int            mptr     = 0;
  logic          exp_en   = 1'b0;
  logic [SW-1:0] exp_sel  = '0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_busy = 1'b0;
  logic [N-1:0]  last_er  = '0;

  logic [N-1:0]  obs_ready;
  logic          obs_en;
  logic [SW-1:0] obs_sel;
  logic [DW-1:0] obs_data;
  logic          obs_busy;
  logic [N-1:0]  grants [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // who should win this cycle; -1 when nobody
  function automatic int model_grant();
    int c;
    if (rst || hold) return -1;
    for (int k = 0; k < N; k++) begin
`ifdef REGFILE_WB_ARBITER_ROUND_ROBIN_EN
      c = (mptr + k) % N;
`else
      c = k;
`endif
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    obs_ready = req_ready;
    obs_en    = wr_en;
    obs_sel   = wr_sel;
    obs_data  = wr_data;
    obs_busy  = busy;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("wr_en",     64'(wr_en),     64'(exp_en));
    chk("wr_sel",    64'(wr_sel),    64'(exp_sel));
    chk("wr_data",   64'(wr_data),   64'(exp_data));
    chk("busy",      64'(busy),      64'(exp_busy));
    if (rst) begin
      exp_en = 1'b0; exp_sel = '0; exp_data = '0; exp_busy = 1'b0; mptr = 0;
    end else begin
      exp_busy = |(req_valid & ~er);
      if (g >= 0) begin
        exp_sel  = req_sel[g*SW +: SW];
        exp_data = req_data[g*DW +: DW];
        exp_en   = (exp_sel != '0);
        mptr     = (g + 1) % N;
      end else begin
        exp_en = 1'b0;
      end
    end
    last_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [SW-1:0] s, input logic [DW-1:0] d);
    req_valid[i]        = v;
    req_sel[i*SW +: SW] = s;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    // reset with every requester valid
    rst = 1'b1;
    req_valid = '1;
    @(posedge clk);
    #1;
    step();
    chk("rst_ready", 64'(obs_ready), 64'(0));
    step();
    chk("rst_wr_en", 64'(obs_en), 64'(0));
    rst = 1'b0;
    req_valid = '0;
    step();

    // single request r5 = DEADBEEF from requester 1
    set_req(1, 1'b1, 4'd5, 32'hDEADBEEF);
    step();
    chk("single_grant", 64'(obs_ready), 64'(3'b010));
    set_req(1, 1'b0, 4'd0, 32'h0);
    step();
    chk("single_wr_en",   64'(obs_en),   64'(1));
    chk("single_wr_sel",  64'(obs_sel),  64'(5));
    chk("single_wr_data", 64'(obs_data), 64'(32'hDEADBEEF));
    step();
    chk("single_idle", 64'(obs_en), 64'(0));

    // all three continuously valid from ptr 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, SW'(i + 1), DW'($urandom));
    for (int k = 0; k < 4; k++) begin
      step();
      grants[k] = obs_ready;
      if (k >= 1) chk("rr_busy", 64'(obs_busy), 64'(1));
    end
`ifdef REGFILE_WB_ARBITER_ROUND_ROBIN_EN
    chk("rr_g0", 64'(grants[0]), 64'(3'b001));
    chk("rr_g1", 64'(grants[1]), 64'(3'b010));
    chk("rr_g2", 64'(grants[2]), 64'(3'b100));
    chk("rr_g3", 64'(grants[3]), 64'(3'b001));
`else
    chk("fp_g0", 64'(grants[0]), 64'(3'b001));
    chk("fp_g1", 64'(grants[1]), 64'(3'b001));
    chk("fp_g2", 64'(grants[2]), 64'(3'b001));
    chk("fp_g3", 64'(grants[3]), 64'(3'b001));
`endif

    // hold for three cycles with requester 0 waiting
    req_valid = '0;
    set_req(0, 1'b1, 4'd9, 32'h0BAD_F00D);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_ready", 64'(obs_ready), 64'(0));
    end
    hold = 1'b0;
    step();
    chk("hold_release", 64'(obs_ready), 64'(3'b001));
    req_valid = '0;
    step();

    // r0 write is consumed but never enabled
    set_req(2, 1'b1, 4'd0, 32'h1234);
    step();
    chk("r0_grant", 64'(obs_ready), 64'(3'b100));
    set_req(2, 1'b0, 4'd0, 32'h0);
    step();
    chk("r0_wr_en", 64'(obs_en), 64'(0));
    step();
    chk("r0_rf", 64'(tb_rf[0]), 64'(0));

    // same-register conflict: loser writes last
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 4'd7, 32'hA);
    set_req(1, 1'b1, 4'd7, 32'hB);
    step();
    chk("conf_g0", 64'(obs_ready), 64'(3'b001));
    set_req(0, 1'b0, 4'd0, 32'h0);
    step();
    chk("conf_g1", 64'(obs_ready), 64'(3'b010));
    req_valid = '0;
    step();
    step();
    chk("conf_r7_b", 64'(tb_rf[7]), 64'(32'hB));

    // conflict again with reset between the two grants
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 4'd7, 32'hA);
    set_req(1, 1'b1, 4'd7, 32'hB);
    step();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    step();
    step();
    chk("conf_rst_r7_a", 64'(tb_rf[7]), 64'(32'hA));

    // randomized traffic; requests stay stable until taken
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || last_er[i])
          set_req(i, 1'($urandom_range(0, 1)), SW'($urandom), DW'($urandom));
      hold = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
